cv32e40p_obi_data_responder: RTL and testbench

CV32E40P_OBI_DATA_RESPONDER -- requirements
Module: cv32e40p_obi_data_responder

---
 rtl/cv32e40p_obi_resp_pkg.sv | 32 +++
 rtl/cv32e40p_obi_resp_delay.sv | 38 +++
 rtl/cv32e40p_obi_data_responder.sv | 142 ++++++++++++++
 tb/tb_cv32e40p_obi_data_responder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_obi_resp_pkg.sv
// Shared types and constants for the OBI data-side responder.
// Consumed by cv32e40p_obi_data_responder and cv32e40p_obi_resp_delay.
package cv32e40p_obi_resp_pkg;

    localparam int unsigned OBI_MAX_OUTSTANDING = 2;
    localparam int unsigned OUTST_W             = 2;
    localparam int unsigned STALL_CNT_W         = 3;
    localparam int unsigned DATA_W              = 32;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              err;
    } obi_resp_t;

    typedef enum logic {
        GS_IDLE  = 1'b0,
        GS_STALL = 1'b1
    } gnt_state_e;

    // Merge the enabled bytes of wdata into old_word.
    function automatic logic [DATA_W-1:0] apply_be(input logic [DATA_W-1:0] old_word,
                                                   input logic [DATA_W-1:0] wdata,
                                                   input logic [3:0]        be);
        logic [DATA_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) merged[8*b +: 8] = wdata[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/cv32e40p_obi_resp_delay.sv
// LAT-deep shift pipeline carrying response valid and payload.
// Payload is forced to zero in empty slots so the output is clean when not valid.
module cv32e40p_obi_resp_delay
    import cv32e40p_obi_resp_pkg::*;
#(
    parameter int unsigned LAT = 1
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      in_valid,
    input  obi_resp_t in_resp,
    output logic      out_valid,
    output obi_resp_t out_resp
);

    logic      valid_q [LAT];
    obi_resp_t resp_q  [LAT];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(LAT); i++) begin
                valid_q[i] <= 1'b0;
                resp_q[i]  <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            resp_q[0]  <= in_valid ? in_resp : '0;
            for (int i = 1; i < int'(LAT); i++) begin
                valid_q[i] <= valid_q[i-1];
                resp_q[i]  <= resp_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[LAT-1];
    assign out_resp  = resp_q[LAT-1];

endmodule

// File: rtl/cv32e40p_obi_data_responder.sv
// OBI data-side memory responder: grant FSM with programmable stall, byte-enable memory,
// fixed-latency in-order responses. Define CV32E40P_OBI_ERR_EN for the out-of-range error port.
module cv32e40p_obi_data_responder
    import cv32e40p_obi_resp_pkg::*;
#(
    parameter int unsigned MEM_WORDS  = 1024,
    parameter int unsigned RVALID_LAT = 1,
    parameter int unsigned GNT_STALL  = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              data_req_i,
    output logic              data_gnt_o,
    input  logic              data_we_i,
    input  logic [3:0]        data_be_i,
    input  logic [31:0]       data_addr_i,
    input  logic [31:0]       data_wdata_i,
    output logic              data_rvalid_o,
    output logic [31:0]       data_rdata_o
`ifdef CV32E40P_OBI_ERR_EN
    ,
    output logic              data_err_o
`endif
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);

    gnt_state_e             state_q, state_d;
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
    logic [OUTST_W-1:0]     outst_q;
    logic                   gnt_c;
    logic                   hs;
    logic [IDX_W-1:0]       idx;
    logic                   addr_err;
    obi_resp_t              resp_c;
    logic                   pipe_valid;
    obi_resp_t              pipe_resp;
    logic                   unused_bits;
    logic [DATA_W-1:0]      mem [MEM_WORDS];

    // Grant FSM: everything freezes while the response window is full.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_c   = 1'b0;
        if (outst_q != OUTST_W'(OBI_MAX_OUTSTANDING)) begin
            unique case (state_q)
                GS_IDLE: begin
                    if (data_req_i) begin
                        if (GNT_STALL == 0) begin
                            gnt_c = 1'b1;
                        end else begin
                            state_d = GS_STALL;
                            cnt_d   = STALL_CNT_W'(1);
                        end
                    end
                end
                GS_STALL: begin
                    if (cnt_q == STALL_CNT_W'(GNT_STALL)) begin
                        gnt_c   = 1'b1;
                        state_d = GS_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + STALL_CNT_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= GS_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign data_gnt_o = gnt_c & ~rst_i;
    assign hs         = data_req_i & data_gnt_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outst_q <= '0;
        end else begin
            unique case ({hs, pipe_valid})
                2'b10:   outst_q <= outst_q + OUTST_W'(1);
                2'b01:   outst_q <= outst_q - OUTST_W'(1);
                default: outst_q <= outst_q;
            endcase
        end
    end

    assign idx = data_addr_i[IDX_W+1:2];

`ifdef CV32E40P_OBI_ERR_EN
    assign addr_err = (data_addr_i[31:IDX_W+2] != '0);
`else
    assign addr_err = 1'b0;
`endif

    // Memory is deliberately left out of reset so completed writes survive it.
    always_ff @(posedge clk_i) begin
        if (hs && data_we_i && !addr_err) begin
            mem[idx] <= apply_be(mem[idx], data_wdata_i, data_be_i);
        end
    end

    // Response captured at the handshake edge: read sees the word as it stands before this edge.
    always_comb begin
        resp_c = '0;
        if (addr_err) begin
            resp_c.err = 1'b1;
        end else if (!data_we_i) begin
            resp_c.rdata = mem[idx];
        end
    end

    cv32e40p_obi_resp_delay #(
        .LAT (RVALID_LAT)
    ) u_delay (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .in_valid  (hs),
        .in_resp   (resp_c),
        .out_valid (pipe_valid),
        .out_resp  (pipe_resp)
    );

    assign data_rvalid_o = pipe_valid;
    assign data_rdata_o  = pipe_resp.rdata;

`ifdef CV32E40P_OBI_ERR_EN
    assign data_err_o  = pipe_resp.err;
    assign unused_bits = ^data_addr_i[1:0];
`else
    assign unused_bits = ^{data_addr_i[1:0], data_addr_i[31:IDX_W+2], pipe_resp.err};
`endif

endmodule

// File: tb/tb_cv32e40p_obi_data_responder.sv
// Three responder configurations driven by shared stimulus; a per-cycle monitor compares
// each against a transaction-level model (word memory + queue of responses due by cycle).
module tb_cv32e40p_obi_data_responder;

    localparam int NDUT = 3;

`ifdef CV32E40P_OBI_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    function automatic int cfg_mem(input int k);
        case (k)
            0:       return 1024;
            1:       return 16;
            default: return 64;
        endcase
    endfunction

    function automatic int cfg_lat(input int k);
        case (k)
            0:       return 1;
            1:       return 2;
            default: return 4;
        endcase
    endfunction

    function automatic int cfg_stall(input int k);
        case (k)
            1:       return 3;
            default: return 0;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt    [NDUT];
    logic        rvalid [NDUT];
    logic [31:0] rdata  [NDUT];
    logic        err    [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned MW = cfg_mem(g);
        localparam int unsigned LT = cfg_lat(g);
        localparam int unsigned ST = cfg_stall(g);
        cv32e40p_obi_data_responder #(
            .MEM_WORDS  (MW),
            .RVALID_LAT (LT),
            .GNT_STALL  (ST)
        ) u_dut (
            .clk_i         (clk),
            .rst_i         (rst),
            .data_req_i    (req),
            .data_gnt_o    (gnt[g]),
            .data_we_i     (we),
            .data_be_i     (be),
            .data_addr_i   (addr),
            .data_wdata_i  (wdata),
            .data_rvalid_o (rvalid[g]),
            .data_rdata_o  (rdata[g])
`ifdef CV32E40P_OBI_ERR_EN
            ,
            .data_err_o    (err[g])
`endif
        );
`ifndef CV32E40P_OBI_ERR_EN
        assign err[g] = 1'b0;
`endif
    end

    // ---------------- reference model and monitor ----------------
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t        q      [NDUT][$];
    logic [31:0] mem_m  [NDUT][1024];
    int          wait_c [NDUT];
    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    bit          done = 1'b0;
    int          n_timeouts = 0;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s dut%0d cycle %0d: got %h expected %h", nm, k, cyc, act, exp);
        else
            n_pass++;
    endtask

    function automatic exp_t model_access(input int k);
        exp_t        e;
        logic [63:0] wa;
        int          w;
        logic [31:0] m;
        wa = 64'(addr) >> 2;
        w  = int'(wa % 64'(cfg_mem(k)));
        m  = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        e.rdata = 32'h0;
        e.err   = 1'b0;
        e.due   = cyc + cfg_lat(k);
        if (ERR_EN && (64'(addr) >= 64'(cfg_mem(k)) * 64'd4))
            e.err = 1'b1;
        else if (we)
            mem_m[k][w] = (mem_m[k][w] & ~m) | (wdata & m);
        else
            e.rdata = mem_m[k][w];
        return e;
    endfunction

    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < NDUT; k++) begin
            if (rst) begin
                chk("gnt_in_reset", k, 32'(gnt[k]), 32'h0);
                q[k].delete();
                wait_c[k] = 0;
            end else begin
                bit   full;
                bit   pending;
                bit   eg;
                bit   ev;
                exp_t e;
                full    = (q[k].size() >= 2);
                pending = req || (wait_c[k] > 0);
                eg      = !full && pending && (wait_c[k] == cfg_stall(k));
                chk("gnt", k, 32'(gnt[k]), 32'(eg));
                ev = (q[k].size() > 0) && (q[k][0].due == cyc);
                chk("rvalid", k, 32'(rvalid[k]), 32'(ev));
                if (ev) begin
                    chk("rdata", k, rdata[k], q[k][0].rdata);
                    chk("err", k, 32'(err[k]), 32'(q[k][0].err));
                    void'(q[k].pop_front());
                end else begin
                    chk("rdata_idle", k, rdata[k], 32'h0);
                    chk("err_idle", k, 32'(err[k]), 32'h0);
                end
                if (!full && pending) wait_c[k] = eg ? 0 : wait_c[k] + 1;
                if (eg && req) begin
                    e = model_access(k);
                    q[k].push_back(e);
                end
            end
        end
        if (done || cyc > 60000) begin
            if (!done) chk("watchdog", 0, 32'h1, 32'h0);
            chk("driver_timeouts", 0, 32'(n_timeouts), 32'h0);
            $display("%0d/%0d checks passed", n_pass, n_total);
            $finish;
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        req = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold the request until every responder has granted it at least once.
    task automatic op(input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d);
        bit got [NDUT];
        bit all;
        int n;
        req = 1'b1; we = w; be = b; addr = a; wdata = d;
        for (int k = 0; k < NDUT; k++) got[k] = 1'b0;
        all = 1'b0;
        n   = 0;
        while (!all && n < 64) begin
            @(negedge clk);
            all = 1'b1;
            for (int k = 0; k < NDUT; k++) begin
                if (gnt[k]) got[k] = 1'b1;
                all = all && got[k];
            end
            n++;
        end
        if (!all) n_timeouts++;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        req = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        for (int i = 0; i < 16; i++) op(1'b1, 4'hF, 32'(i * 4), $urandom);

        op(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
        op(1'b0, 4'h0, 32'h10, 32'h0);
        op(1'b1, 4'hF, 32'h20, 32'hFFFFFFFF);
        op(1'b1, 4'h5, 32'h20, 32'h11223344);
        op(1'b0, 4'h0, 32'h20, 32'h0);
        idle(6);

        op(1'b0, 4'h0, 32'h24, 32'h0);
        op(1'b0, 4'h0, 32'h28, 32'h0);
        op(1'b0, 4'h0, 32'h2C, 32'h0);
        idle(6);

        op(1'b0, 4'h0, 32'h10, 32'h0);
        reset_pulse();
        idle(3);
        op(1'b0, 4'h0, 32'h10, 32'h0);
        op(1'b0, 4'h0, 32'h20, 32'h0);

        op(1'b1, 4'hF, 32'h1000, 32'hA5A5A5A5);
        op(1'b0, 4'h0, 32'h1000, 32'h0);
        op(1'b0, 4'h0, 32'h0, 32'h0);
        idle(4);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] hi;
            logic [31:0] a;
            hi = ($urandom_range(0, 1) == 1) ? $urandom : 32'h0;
            a  = (hi << 12) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            op(1'($urandom), 4'($urandom), a, $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            if (i % 100 == 50) begin
                reset_pulse();
                idle(2);
            end
        end

        idle(10);
        done = 1'b1;
    end

endmodule
